// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: single-outstanding imem fetcher feeding a DEPTH-entry {pc, instr} FIFO to decode.
// Define FETCH_BYPASS_EN to hand a response straight to decode when the queue is empty.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [31:0]            imem_addr,
   input  logic                   imem_ack,
   input  logic [31:0]            imem_rdata,
   output logic                   instr_valid,
   output logic [31:0]            instr,
   output logic [31:0]            instr_pc,
   input  logic                   instr_ready,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   state_t          r_state, w_next;
   logic [AW:0]     r_count, w_count_nxt;
   logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
   logic [31:0]     r_fetch_pc, r_req_pc;
   logic [31:0]     r_q_pc [DEPTH];
   logic [31:0]     r_q_instr [DEPTH];
   logic            w_ack_keep, w_head_valid, w_bypass, w_pop, w_push, w_issue;
   assign w_ack_keep   = (r_state == WAIT) && imem_ack && !redirect && !reset;
   assign w_head_valid = |r_count;
`ifdef FETCH_BYPASS_EN
   assign w_bypass = !w_head_valid && w_ack_keep;
   assign instr    = w_head_valid ? r_q_instr[r_rd_ptr] : imem_rdata;
   assign instr_pc = w_head_valid ? r_q_pc[r_rd_ptr] : r_req_pc;
`else
   assign w_bypass = 1'b0;
   assign instr    = r_q_instr[r_rd_ptr];
   assign instr_pc = r_q_pc[r_rd_ptr];
`endif
   assign w_pop       = w_head_valid && instr_ready && !redirect;
   assign w_push      = w_ack_keep && !(w_bypass && instr_ready);
   assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
   // A new request is only issued when its response is sure to find a free entry.
   assign w_issue     = !redirect && !reset &&
                        ((r_state == IDLE && r_count != FULL) || (w_ack_keep && w_count_nxt != FULL));
   assign imem_req    = w_issue;
   assign imem_addr   = r_fetch_pc;
   assign instr_valid = !reset && (w_head_valid || w_bypass);
   assign occupancy   = reset ? '0 : r_count;
   always_comb begin
      w_next = w_issue ? WAIT : (r_state == IDLE || imem_ack) ? IDLE : redirect ? DROP : r_state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
      end else begin
         r_state <= w_next;
         if (w_issue) r_req_pc <= r_fetch_pc;
         if (redirect) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= redirect_pc;
         end else begin
            r_count <= w_count_nxt;
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr]    <= r_req_pc;
         r_q_instr[r_wr_ptr] <= imem_rdata;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(w_push && r_count == FULL));
         assert (!(r_state == IDLE && imem_ack));
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: randomized and directed checks of instr_fetch_queue against a queue-based model
// of the fetch stream (honours FETCH_BYPASS_EN when defined).
module tb_instr_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam int          OW       = $clog2(DEPTH) + 1;
   localparam int          VW       = 98 + OW;
   localparam logic [31:0] RESET_PC = 32'h0;
   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           imem_req, imem_ack = 1'b0;
   logic [31:0]    imem_addr, imem_rdata = 32'h0;
   logic           instr_valid, instr_ready = 1'b0;
   logic [31:0]    instr, instr_pc;
   logic           redirect = 1'b0;
   logic [31:0]    redirect_pc = 32'h0;
   logic [OW-1:0]  occupancy;
   int             n_checks = 0, n_fail = 0;
   logic [31:0]    q_pc[$], delivered[$], reqs[$];
   logic [31:0]    m_fetch = RESET_PC, m_req_pc = 32'h0, pend_addr = 32'h0;
   bit             pend = 1'b0, keep = 1'b0;
   int             lat = 0, fix_lat = 1;
   logic           o_req, o_valid;
   logic [31:0]    o_addr, o_pc;
   logic [OW-1:0]  o_occ;
   logic [VW-1:0]  obs_vec, exp_vec;
   always #5 clk = ~clk;
   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .occupancy(occupancy)
   );
   function automatic logic [31:0] img(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction
   // One clock: drive inputs, sample outputs, predict them from the model, then advance model and memory.
   task automatic tick(input bit rd, input logic [31:0] rpc, input bit rdy, input bit rst);
      bit cur_ack, ack_keep, byp, pop, push, e_req, e_valid;
      int sz, sz_after;
      logic [31:0] head;
      @(negedge clk);
      reset = rst; redirect = rd; redirect_pc = rpc; instr_ready = rdy;
      cur_ack = pend && lat == 0;
      imem_ack = cur_ack;
      imem_rdata = cur_ack ? img(pend_addr) : $urandom;
      #1;
      o_req = imem_req; o_addr = imem_addr; o_valid = instr_valid; o_pc = instr_pc; o_occ = occupancy;
      sz = q_pc.size();
      ack_keep = cur_ack && keep && !rd && !rst;
`ifdef FETCH_BYPASS_EN
      byp = sz == 0 && ack_keep;
`else
      byp = 1'b0;
`endif
      pop = sz != 0 && rdy && !rd && !rst;
      push = ack_keep && !(byp && rdy);
      sz_after = sz - int'(pop) + int'(push);
      e_req = !rd && !rst && ((!pend && sz < DEPTH) || (ack_keep && sz_after < DEPTH));
      e_valid = !rst && (sz != 0 || byp);
      head = sz != 0 ? q_pc[0] : m_req_pc;
      exp_vec = {e_req, e_req ? m_fetch : 32'h0, e_valid, e_valid ? head : 32'h0,
                 e_valid ? img(head) : 32'h0, rst ? OW'(0) : OW'(sz)};
      obs_vec = {imem_req, imem_req ? imem_addr : 32'h0, instr_valid, instr_valid ? instr_pc : 32'h0,
                 instr_valid ? instr : 32'h0, occupancy};
      if (instr_valid && rdy && !rd && !rst) delivered.push_back(instr_pc);
      if (imem_req) reqs.push_back(imem_addr);
      if (rst) begin
         q_pc.delete(); m_fetch = RESET_PC; m_req_pc = 32'h0;
      end else if (rd) begin
         q_pc.delete(); m_fetch = rpc;
      end else begin
         if (pop) void'(q_pc.pop_front());
         if (push) q_pc.push_back(m_req_pc);
         if (e_req) begin m_req_pc = m_fetch; m_fetch = m_fetch + 32'd4; end
      end
      if (rd || rst) keep = 1'b0;
      if (rst || cur_ack) pend = 1'b0;
      else if (pend) lat--;
      if (imem_req && !rst) begin
         pend = 1'b1; keep = 1'b1; pend_addr = imem_addr;
         lat = (fix_lat > 0 ? fix_lat : int'($urandom_range(1, 4))) - 1;
      end
   endtask
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(0, 32'h0, 1, 1);
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", obs_vec, exp_vec); end
      end
      reqs.delete();
      tick(0, 32'h0, 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL reset_exit got=%h exp=%h", obs_vec, exp_vec); end
      n_checks++;
      if (reqs.size() != 1 || o_addr !== RESET_PC) begin
         n_fail++; $display("FAIL reset_first_addr got=%h (reqs %0d) exp=%h", o_addr, reqs.size(), RESET_PC);
      end
   endtask
   task automatic test_stream();
      int bad = 0;
      fix_lat = 1;
      tick(0, 32'h0, 1, 1);
      reqs.delete(); delivered.delete();
      for (int i = 0; i < 40; i++) begin
         tick(0, 32'h0, 1, 0);
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
      end
      n_checks++;
      if (reqs.size() != 40) begin n_fail++; $display("FAIL stream_req_rate got=%0d exp=40", reqs.size()); end
      foreach (delivered[i]) if (delivered[i] !== 32'(4 * i)) bad++;
      n_checks++;
      if (bad != 0 || delivered.size() < 30) begin
         n_fail++; $display("FAIL stream_order got=%0d bad of %0d exp=0 bad of >=30", bad, delivered.size());
      end
   endtask
   task automatic test_full();
      fix_lat = 1;
      tick(0, 32'h0, 0, 1);
      reqs.delete(); delivered.delete();
      for (int i = 0; i < 12; i++) begin
         tick(0, 32'h0, 0, 0);
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL full_fill cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
      end
      n_checks++;
      if (reqs.size() != 4 || reqs[0] !== 32'h0 || reqs[3] !== 32'hC || o_occ !== OW'(4) || o_req !== 1'b0) begin
         n_fail++; $display("FAIL full_stop got=reqs %0d occ %0d req %b exp=reqs 4 (0..C) occ 4 req 0", reqs.size(), o_occ, o_req);
      end
      reqs.delete();
      for (int i = 0; i < 8; i++) begin
         tick(0, 32'h0, 1, 0);
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL full_drain cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
      end
      n_checks++;
      if (delivered.size() < 4 || delivered[0] !== 32'h0 || delivered[1] !== 32'h4 ||
          delivered[2] !== 32'h8 || delivered[3] !== 32'hC) begin
         n_fail++; $display("FAIL full_pop_order got=%0d pops exp=0,4,8,C first", delivered.size());
      end
      n_checks++;
      if (reqs.size() == 0 || reqs[0] !== 32'h10) begin
         n_fail++; $display("FAIL full_next_addr got=%h exp=00000010", reqs.size() ? reqs[0] : 32'hx);
      end
   endtask
   task automatic test_redirect_wait();
      int bad = 0;
      fix_lat = 3;
      tick(0, 32'h0, 1, 1);
      for (int i = 0; i < 20 && !(o_req && o_addr == 32'h8); i++) tick(0, 32'h0, 1, 0);
      n_checks++;
      if (!(o_req && o_addr == 32'h8)) begin n_fail++; $display("FAIL redir_wait_setup got=no req 8 exp=req 8"); end
      tick(1, 32'h100, 1, 0);
      reqs.delete(); delivered.delete();
      for (int i = 0; i < 20; i++) begin
         tick(0, 32'h0, 1, 0);
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL redir_wait cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
      end
      foreach (delivered[i]) if (delivered[i] == 32'h8) bad++;
      n_checks++;
      if (bad != 0 || delivered.size() == 0 || delivered[0] !== 32'h100 || reqs.size() == 0 || reqs[0] !== 32'h100) begin
         n_fail++; $display("FAIL redir_wait_stream got=%0d stale, %0d pops, %0d reqs exp=0 stale, first pc/req 100", bad, delivered.size(), reqs.size());
      end
   endtask
   task automatic test_redirect_ack();
      fix_lat = 2;
      tick(0, 32'h0, 1, 1);
      tick(0, 32'h0, 1, 0);
      for (int i = 0; i < 20 && !(pend && lat == 0); i++) tick(0, 32'h0, 1, 0);
      n_checks++;
      if (!(pend && lat == 0)) begin n_fail++; $display("FAIL redir_ack_setup got=no ack due exp=ack due"); end
      tick(1, 32'h200, 1, 0);
      tick(0, 32'h0, 1, 0);
      n_checks++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL redir_ack_model got=%h exp=%h", obs_vec, exp_vec); end
      n_checks++;
      if (o_occ !== OW'(0) || o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h200) begin
         n_fail++; $display("FAIL redir_ack got=occ %0d valid %b req %b addr %h exp=occ 0 valid 0 req 1 addr 200", o_occ, o_valid, o_req, o_addr);
      end
   endtask
   task automatic test_flush_full();
      fix_lat = 1;
      tick(0, 32'h0, 0, 1);
      for (int i = 0; i < 10; i++) tick(0, 32'h0, 0, 0);
      n_checks++;
      if (o_occ !== OW'(4)) begin n_fail++; $display("FAIL flush_fill got=%0d exp=4", o_occ); end
      tick(1, 32'h40, 1, 0);
      reqs.delete(); delivered.delete();
      tick(0, 32'h0, 0, 0);
      n_checks++;
      if (o_occ !== OW'(0) || o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h40) begin
         n_fail++; $display("FAIL flush_full got=occ %0d valid %b req %b addr %h exp=occ 0 valid 0 req 1 addr 40", o_occ, o_valid, o_req, o_addr);
      end
      for (int i = 0; i < 12; i++) begin
         tick(0, 32'h0, 1, 0);
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL flush_resume cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
      end
      n_checks++;
      if (delivered.size() == 0 || delivered[0] !== 32'h40) begin
         n_fail++; $display("FAIL flush_first_pc got=%h exp=00000040", delivered.size() ? delivered[0] : 32'hx);
      end
   endtask
   task automatic test_bypass();
      fix_lat = 2;
      tick(0, 32'h0, 1, 1);
      tick(0, 32'h0, 1, 0);
      for (int i = 0; i < 20 && !(pend && lat == 0); i++) tick(0, 32'h0, 1, 0);
      tick(0, 32'h0, 1, 0);
`ifdef FETCH_BYPASS_EN
      n_checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h0) begin n_fail++; $display("FAIL bypass_same_cycle got=valid %b pc %h exp=valid 1 pc 0", o_valid, o_pc); end
      tick(0, 32'h0, 1, 0);
      n_checks++;
      if (o_occ !== OW'(0)) begin n_fail++; $display("FAIL bypass_occ got=%0d exp=0", o_occ); end
`else
      n_checks++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_ack_cycle got=valid %b exp=valid 0", o_valid); end
      tick(0, 32'h0, 1, 0);
      n_checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_occ !== OW'(1)) begin
         n_fail++; $display("FAIL nobypass_next got=valid %b pc %h occ %0d exp=valid 1 pc 0 occ 1", o_valid, o_pc, o_occ);
      end
      tick(0, 32'h0, 1, 0);
      n_checks++;
      if (o_occ !== OW'(0)) begin n_fail++; $display("FAIL nobypass_drain got=%0d exp=0", o_occ); end
`endif
   endtask
   task automatic test_random();
      fix_lat = 0;
      tick(0, 32'h0, 1, 1);
      for (int i = 0; i < 800; i++) begin
         tick($urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
      end
   endtask
   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_ack();
      test_flush_full();
      test_bypass();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
